// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad decimal entry block.
// The key code is row_index*4 + col_index.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } db_state_t;

    typedef enum logic [1:0] {
        KF_NONE,
        KF_DIGIT,
        KF_ENTER,
        KF_CLEAR
    } key_kind_t;

    typedef struct packed {
        key_kind_t  kind;
        logic [3:0] value;
    } key_func_t;

    localparam logic [3:0] KEY_CLEAR = 4'd12;
    localparam logic [3:0] KEY_ENTER = 4'd14;

    // Layout: row0 {1,2,3,A}, row1 {4,5,6,B}, row2 {7,8,9,C}, row3 {*,0,#,D}.
    function automatic key_func_t key_map(input logic [3:0] code);
        key_func_t f;
        f = '{kind: KF_NONE, value: 4'd0};
        unique case (code)
            4'd0:      f = '{kind: KF_DIGIT, value: 4'd1};
            4'd1:      f = '{kind: KF_DIGIT, value: 4'd2};
            4'd2:      f = '{kind: KF_DIGIT, value: 4'd3};
            4'd4:      f = '{kind: KF_DIGIT, value: 4'd4};
            4'd5:      f = '{kind: KF_DIGIT, value: 4'd5};
            4'd6:      f = '{kind: KF_DIGIT, value: 4'd6};
            4'd8:      f = '{kind: KF_DIGIT, value: 4'd7};
            4'd9:      f = '{kind: KF_DIGIT, value: 4'd8};
            4'd10:     f = '{kind: KF_DIGIT, value: 4'd9};
            4'd13:     f = '{kind: KF_DIGIT, value: 4'd0};
            KEY_CLEAR: f = '{kind: KF_CLEAR, value: 4'd0};
            KEY_ENTER: f = '{kind: KF_ENTER, value: 4'd0};
            default:   f = '{kind: KF_NONE,  value: 4'd0};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner, row synchronizer and press/release debouncer.
// Emits a single-cycle key_event with key_code when a press is confirmed.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_event,
    output logic [3:0] key_code
);

    localparam int CW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0]  tick_cnt;
    logic           tick;
    logic           sample;
    logic [1:0]     col_idx;
    logic [3:0]     row_meta;
    logic [3:0]     row_sync;
    logic [3:0]     row_low;
    logic [1:0]     row_idx;
    logic [2:0]     total_hits;
    logic [1:0]     hits_acc;
    logic [1:0]     hits_now;
    logic [3:0]     code_acc;
    logic [3:0]     code_now;
    logic           scan_done;
    logic           scan_single;
    logic [3:0]     scan_code;
    db_state_t      state;
    db_state_t      next_state;
    logic [DBW-1:0] db_cnt;
    logic [3:0]     cand;
    logic           db_done;
    logic           match;

    assign tick    = (tick_cnt == CW'(SCAN_DIV - 1));
    assign sample  = (tick_cnt == CW'(SCAN_DIV - 2));
    assign col     = ~(4'b0001 << col_idx);
    assign row_low = ~row_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            col_idx  <= 2'd0;
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) col_idx <= col_idx + 2'd1;
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_low[i]) row_idx = 2'(i);
        end
        total_hits = {1'b0, hits_acc} + 3'(row_low[0]) + 3'(row_low[1])
                   + 3'(row_low[2]) + 3'(row_low[3]);
        hits_now   = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
        code_now   = (row_low != 4'h0) ? {row_idx, col_idx} : code_acc;
    end

    // Hit count saturates at 2: anything above one low position is "no key".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_acc    <= 2'd0;
            code_acc    <= 4'd0;
            scan_done   <= 1'b0;
            scan_single <= 1'b0;
            scan_code   <= 4'd0;
        end else begin
            scan_done <= 1'b0;
            if (sample) begin
                if (col_idx == 2'd3) begin
                    scan_done   <= 1'b1;
                    scan_single <= (hits_now == 2'd1);
                    scan_code   <= code_now;
                    hits_acc    <= 2'd0;
                end else begin
                    hits_acc <= hits_now;
                    code_acc <= code_now;
                end
            end
        end
    end

    assign match   = scan_single && (scan_code == cand);
    assign db_done = (db_cnt >= DBW'(DEBOUNCE_SCANS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            db_cnt <= '0;
            cand   <= 4'd0;
        end else begin
            state <= next_state;
            if (scan_done) begin
                // The scan that enters a debounce state counts as its first scan.
                if (state != next_state)
                    db_cnt <= DBW'(1);
                else if (!db_done)
                    db_cnt <= db_cnt + 1'b1;
                if (state == IDLE && scan_single)
                    cand <= scan_code;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (scan_done) begin
            unique case (state)
                IDLE:       if (scan_single) next_state = PRESS_DB;
                PRESS_DB:   if (!match) next_state = IDLE;
                            else if (db_done) next_state = HELD;
                HELD:       if (!scan_single) next_state = RELEASE_DB;
                RELEASE_DB: if (scan_single) next_state = HELD;
                            else if (db_done) next_state = IDLE;
                default:    next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        key_event = (state == PRESS_DB) && (next_state == HELD);
        key_code  = cand;
    end

endmodule

// File: rtl/keypad_decimal_entry.sv
// Keypad-driven decimal entry: accumulates up to three digits into 0..255
// and commits the value on '#', clears on '*'.
module keypad_decimal_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] entry,
    output logic [1:0] digits,
    output logic       overflow,
    output logic [7:0] number,
    output logic       number_valid
);

    logic       key_event;
    logic [3:0] key_code;
    key_func_t  func;
    logic [11:0] mac;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_event (key_event),
        .key_code  (key_code)
    );

    // Wide enough that 25*10+9 = 259 is seen as out of range, never wrapped.
    assign func = key_map(key_code);
    assign mac  = 12'(entry) * 12'd10 + 12'(func.value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry        <= 8'd0;
            digits       <= 2'd0;
            overflow     <= 1'b0;
            number       <= 8'd0;
            number_valid <= 1'b0;
        end else begin
            number_valid <= 1'b0;
            if (key_event) begin
                unique case (func.kind)
                    KF_DIGIT: begin
                        if (digits < 2'd3 && mac <= 12'd255) begin
                            entry  <= mac[7:0];
                            digits <= digits + 2'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    KF_ENTER: begin
                        number       <= entry;
                        number_valid <= 1'b1;
                        entry        <= 8'd0;
                        digits       <= 2'd0;
                        overflow     <= 1'b0;
                    end
                    KF_CLEAR: begin
                        entry    <= 8'd0;
                        digits   <= 2'd0;
                        overflow <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_decimal_entry.sv
// Directed bench for keypad_decimal_entry with a behavioural 4x4 keypad model.
// Key codes: 1=0 2=1 3=2 A=3 4=4 5=5 6=6 B=7 7=8 8=9 9=10 C=11 *=12 0=13 #=14 D=15.
module tb_keypad_decimal_entry;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int SCAN_CYCLES    = 4 * SCAN_DIV;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] entry;
    logic [1:0] digits;
    logic       overflow;
    logic [7:0] number;
    logic       number_valid;

    logic [15:0] pressed;
    int          tests;
    int          failed;
    int          nv_count;

    typedef struct {
        logic [3:0] code;
        logic [7:0] entry;
        logic [1:0] digits;
        logic       ovf;
        logic [7:0] number;
        int         nv;
    } vec_t;

    vec_t vecs[$];

    keypad_decimal_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row          (row),
        .col          (col),
        .entry        (entry),
        .digits       (digits),
        .overflow     (overflow),
        .number       (number),
        .number_valid (number_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (!reset && number_valid) nv_count++;
    end

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN_CYCLES) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] code);
        @(negedge clk);
        pressed[code] = 1'b1;
        wait_scans(5);
        pressed[code] = 1'b0;
        wait_scans(5);
    endtask

    task automatic add_vec(input logic [3:0] code, input logic [7:0] e, input logic [1:0] d,
                           input logic o, input logic [7:0] n, input int nv);
        vec_t v;
        v = '{code: code, entry: e, digits: d, ovf: o, number: n, nv: nv};
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input int e, input int d, input int o, input int n);
        check({tag, " entry"},    int'(entry),    e);
        check({tag, " digits"},   int'(digits),   d);
        check({tag, " overflow"}, int'(overflow), o);
        check({tag, " number"},   int'(number),   n);
    endtask

    initial begin
        logic [3:0] pat [4];
        int         nv_before;
        int         waited;

        tests    = 0;
        failed   = 0;
        nv_count = 0;
        pressed  = '0;
        reset    = 1'b1;
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

        // key, entry, digits, overflow, number, number_valid pulses
        add_vec(4'd0,  8'd1,   2'd1, 1'b0, 8'd0,   0);
        add_vec(4'd1,  8'd12,  2'd2, 1'b0, 8'd0,   0);
        add_vec(4'd9,  8'd128, 2'd3, 1'b0, 8'd0,   0);
        add_vec(4'd14, 8'd0,   2'd0, 1'b0, 8'd128, 1);
        add_vec(4'd1,  8'd2,   2'd1, 1'b0, 8'd128, 0);
        add_vec(4'd5,  8'd25,  2'd2, 1'b0, 8'd128, 0);
        add_vec(4'd10, 8'd25,  2'd2, 1'b1, 8'd128, 0);
        add_vec(4'd6,  8'd25,  2'd2, 1'b1, 8'd128, 0);
        add_vec(4'd14, 8'd0,   2'd0, 1'b0, 8'd25,  1);
        add_vec(4'd4,  8'd4,   2'd1, 1'b0, 8'd25,  0);
        add_vec(4'd12, 8'd0,   2'd0, 1'b0, 8'd25,  0);
        add_vec(4'd14, 8'd0,   2'd0, 1'b0, 8'd0,   1);
        add_vec(4'd3,  8'd0,   2'd0, 1'b0, 8'd0,   0);
        add_vec(4'd0,  8'd1,   2'd1, 1'b0, 8'd0,   0);
        add_vec(4'd1,  8'd12,  2'd2, 1'b0, 8'd0,   0);
        add_vec(4'd2,  8'd123, 2'd3, 1'b0, 8'd0,   0);
        add_vec(4'd4,  8'd123, 2'd3, 1'b1, 8'd0,   0);
        add_vec(4'd12, 8'd0,   2'd0, 1'b0, 8'd0,   0);
        add_vec(4'd13, 8'd0,   2'd1, 1'b0, 8'd0,   0);
        add_vec(4'd15, 8'd0,   2'd1, 1'b0, 8'd0,   0);
        add_vec(4'd1,  8'd2,   2'd2, 1'b0, 8'd0,   0);
        add_vec(4'd5,  8'd25,  2'd3, 1'b0, 8'd0,   0);
        add_vec(4'd5,  8'd25,  2'd3, 1'b1, 8'd0,   0);
        add_vec(4'd14, 8'd0,   2'd0, 1'b0, 8'd25,  1);
        add_vec(4'd1,  8'd2,   2'd1, 1'b0, 8'd25,  0);
        add_vec(4'd5,  8'd25,  2'd2, 1'b0, 8'd25,  0);
        add_vec(4'd5,  8'd255, 2'd3, 1'b0, 8'd25,  0);
        add_vec(4'd14, 8'd0,   2'd0, 1'b0, 8'd255, 1);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset col", int'(col), 4'b1110);
        check_outputs("reset", 0, 0, 0, 0);
        check("reset number_valid", int'(number_valid), 0);
        reset = 1'b0;

        // Column rotation: one step every SCAN_DIV cycles
        waited = 0;
        while (col == 4'b1110 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("col first step timeout", int'(col != 4'b1110), 1);
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < SCAN_DIV; j++) begin
                check($sformatf("col step %0d", k), int'(col), int'(pat[k % 4]));
                @(negedge clk);
            end
        end

        // Table-driven key sequence
        for (int i = 0; i < vecs.size(); i++) begin
            nv_before = nv_count;
            press_key(vecs[i].code);
            check_outputs($sformatf("vec%0d", i), int'(vecs[i].entry), int'(vecs[i].digits),
                          int'(vecs[i].ovf), int'(vecs[i].number));
            check($sformatf("vec%0d number_valid pulses", i), nv_count - nv_before, vecs[i].nv);
        end

        // Key 7 bouncing for one scan only
        @(negedge clk);
        pressed[8] = 1'b1;
        repeat (SCAN_CYCLES) @(negedge clk);
        pressed[8] = 1'b0;
        wait_scans(5);
        check("bounce entry", int'(entry), 0);
        check("bounce digits", int'(digits), 0);

        // Key 7 held for 10 scans: exactly one event
        pressed[8] = 1'b1;
        wait_scans(10);
        check("hold7 entry", int'(entry), 7);
        check("hold7 digits", int'(digits), 1);
        pressed[8] = 1'b0;
        wait_scans(5);
        check("hold7 released entry", int'(entry), 7);
        check("hold7 released digits", int'(digits), 1);
        press_key(4'd12);
        check("clear after 7", int'(entry), 0);

        // Keys 1 and 5 together, then release 5
        nv_before = nv_count;
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        wait_scans(6);
        check("multi entry", int'(entry), 0);
        check("multi digits", int'(digits), 0);
        pressed[5] = 1'b0;
        wait_scans(4);
        check("multi release5 entry", int'(entry), 1);
        check("multi release5 digits", int'(digits), 1);
        wait_scans(4);
        check("multi still held digits", int'(digits), 1);
        pressed[0] = 1'b0;
        wait_scans(5);
        check("multi number_valid pulses", nv_count - nv_before, 0);
        press_key(4'd12);

        // Reset while 9 is held, then keep 9 held
        pressed[10] = 1'b1;
        wait_scans(5);
        check("held9 entry", int'(entry), 9);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midpress reset col", int'(col), 4'b1110);
        check_outputs("midpress reset", 0, 0, 0, 0);
        check("midpress reset number_valid", int'(number_valid), 0);
        reset = 1'b0;
        wait_scans(6);
        check("after reset held9 entry", int'(entry), 9);
        check("after reset held9 digits", int'(digits), 1);
        pressed[10] = 1'b0;
        wait_scans(5);
        check_outputs("after reset released9", 9, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/keypad_decimal_entry.md
KEYPAD_DECIMAL_ENTRY -- requirements
Module: keypad_decimal_entry

Interface
REQ-001 Parameter SCAN_DIV, 50_000, clk cycles per column period; SHALL be >= 2.
REQ-002 Parameter DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  column drive, active-low, one-hot-low.
REQ-007 entry  output  8  live accumulator value, for the display driver.
REQ-008 digits  output  2  digits accepted into the current entry (0..3).
REQ-009 overflow  output  1  set when a digit was rejected in the current entry.
REQ-010 number  output  8  last committed value, binary 0..255.
REQ-011 number_valid  output  1  one-cycle pulse when number updates.

Function
REQ-012 A free-running tick counter SHALL assert an internal tick every SCAN_DIV clk cycles; no derived clocks.
REQ-013 On each tick col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110; four column periods form one full scan.
REQ-014 row SHALL pass through a 2-flop synchronizer; sampling SHALL occur on the cycle before each tick (settled column).
REQ-015 Key code SHALL be row_index*4 + col_index; layout row0 {1,2,3,A}, row1 {4,5,6,B}, row2 {7,8,9,C}, row3 {*,0,#,D}.
REQ-016 A scan with zero low rows across all columns SHALL be "no key"; a scan with more than one low position SHALL also be "no key".
REQ-017 Debounce FSM: IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-018 IDLE -> PRESS_DB on a single-key scan; the candidate code is latched.
REQ-019 PRESS_DB -> HELD after DEBOUNCE_SCANS consecutive scans showing the candidate; a differing scan SHALL return to IDLE.
REQ-020 Entering HELD SHALL emit exactly one internal key event; holding the key SHALL NOT repeat.
REQ-021 HELD -> RELEASE_DB on a no-key scan; RELEASE_DB -> IDLE after DEBOUNCE_SCANS consecutive no-key scans; any key scan in RELEASE_DB SHALL return to HELD without a new event.
REQ-022 Digit event: if digits < 3 and entry*10 + d <= 255, then entry <= entry*10 + d and digits increments; otherwise overflow <= 1 and entry and digits are unchanged.
REQ-023 '#' event: number <= entry and number_valid pulses one cycle, even when digits == 0 (commits 0); entry, digits and overflow are then cleared.
REQ-024 '*' event: entry, digits and overflow SHALL clear; number is unchanged and number_valid stays 0.
REQ-025 A-D events SHALL be ignored.
REQ-026 Multiply-accumulate SHALL use at least 10-bit intermediate width, so 25*10+9 = 259 is detected and no truncation occurs.
REQ-027 Key event to output update latency SHALL be one clk cycle.

Reset
REQ-028 While reset is high: col = 1110, entry = 0, digits = 0, overflow = 0, number = 0, number_valid = 0, FSM = IDLE, and the tick counter and synchronizers are cleared.
REQ-029 Reset asserted mid-press SHALL discard the press; a key still held after reset release SHALL be re-debounced and accepted once.

Structure
REQ-030 Shared package keypad_pkg SHALL hold the FSM state enum, the 16-entry key-code-to-function map (digit value / ENTER / CLEAR / NONE) and the constants KEY_ENTER and KEY_CLEAR.
REQ-031 Sub-module keypad_scanner SHALL contain the tick counter, column drive, synchronizer and debounce FSM, and output key_event and key_code; the decimal accumulator SHALL live in the top level.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-032 Press and release 1, 2, 8, then # -> entry steps 1, 12, 128; number = 128 with one number_valid pulse; entry = 0 afterwards.
REQ-033 Enter 2, 5, 9 -> overflow = 1 and entry = 25; then 6 -> entry = 256 is never reached and entry stays 25; # -> number = 25.
REQ-034 Key 7 bouncing low for 1 scan only -> no event and entry unchanged; key 7 held for 10 scans -> exactly one event, entry = 7.
REQ-035 Keys 1 and 5 pressed together -> no event; release 5 -> after 2 scans key 1 is accepted once.
REQ-036 Enter 4, then *, then # -> entry = 0 after *; number = 0 with number_valid pulsing once.
REQ-037 Assert reset while 9 is held in HELD -> all outputs at reset values; keep 9 held after reset release -> one event, entry = 9.
